// File: rtl/sprite_compositor_pkg.sv
// Shared types and constants for the sprite compositor.
// Build option: SPR_FLIP_EN adds a per-slot horizontal mirror bit to the attribute record.
package sprite_compositor_pkg;

  localparam int PIX_W   = 16;
  localparam int CRD_W   = 11;
  localparam int SZ_W    = 9;
  localparam int TEX_AW  = 14;
  localparam int SPR_LAT = 3;
  localparam logic [PIX_W-1:0] KEY_COLOR_DEF = 16'hFFFF;

  typedef struct packed {
    logic              en;
`ifdef SPR_FLIP_EN
    logic              flip;
`endif
    logic [CRD_W-1:0]  x;
    logic [CRD_W-1:0]  y;
    logic [SZ_W-1:0]   w;
    logic [SZ_W-1:0]   h;
    logic [TEX_AW-1:0] base;
  } attr_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel stream, texture/attribute load port and composited output of the sprite compositor.
// master = source/sink side (timing generator, loader, display), slave = compositor.
interface sprite_compositor_if
  import sprite_compositor_pkg::*;
#(
  parameter int NUM_SPR = 4
) ();
  localparam int IDX_W = idx_w(NUM_SPR);

  logic              pix_valid;
  logic [CRD_W-1:0]  pixel_x;
  logic [CRD_W-1:0]  pixel_y;
  logic [PIX_W-1:0]  bg_data;
  logic              frame_en;
  logic              tex_wr_en;
  logic [TEX_AW-1:0] tex_wr_addr;
  logic [PIX_W-1:0]  tex_wr_data;
  logic              attr_wr_en;
  logic [IDX_W-1:0]  attr_wr_idx;
  logic [CRD_W-1:0]  attr_x;
  logic [CRD_W-1:0]  attr_y;
  logic [SZ_W-1:0]   attr_w;
  logic [SZ_W-1:0]   attr_h;
  logic [TEX_AW-1:0] attr_base;
  logic              attr_en;
  logic              attr_flip;
  logic              pix_valid_o;
  logic [PIX_W-1:0]  pixel_out;

  modport master (
    output pix_valid, pixel_x, pixel_y, bg_data, frame_en,
           tex_wr_en, tex_wr_addr, tex_wr_data,
           attr_wr_en, attr_wr_idx, attr_x, attr_y, attr_w, attr_h,
           attr_base, attr_en, attr_flip,
    input  pix_valid_o, pixel_out
  );

  modport slave (
    input  pix_valid, pixel_x, pixel_y, bg_data, frame_en,
           tex_wr_en, tex_wr_addr, tex_wr_data,
           attr_wr_en, attr_wr_idx, attr_x, attr_y, attr_w, attr_h,
           attr_base, attr_en, attr_flip,
    output pix_valid_o, pixel_out
  );
endinterface

// File: rtl/sprite_compositor_hit_unit.sv
// Per-slot hit test (S0) and texel address generation (S1); two register stages.
// Build option: SPR_FLIP_EN mirrors the column index when the slot's flip bit is set.
module sprite_hit_unit
  import sprite_compositor_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CRD_W-1:0]  px,
  input  logic [CRD_W-1:0]  py,
  input  attr_t             attr,
  output logic              hit_o,
  output logic [TEX_AW-1:0] addr_o
);
  localparam int XW    = CRD_W + 1;
  localparam int SUM_W = ((TEX_AW > 2 * SZ_W) ? TEX_AW : 2 * SZ_W) + 1;

  logic [XW-1:0]     x_end, y_end;
  logic              s0_hit_d, s0_hit_q;
  logic [SZ_W-1:0]   dx_d, dx_q, dy_d, dy_q, w_d, w_q;
  logic [TEX_AW-1:0] base_d, base_q;
  logic [SZ_W-1:0]   dx_eff;
  logic              s1_hit_d, s1_hit_q;
  logic [TEX_AW-1:0] addr_d, addr_q;
`ifdef SPR_FLIP_EN
  logic              flip_d, flip_q;
`endif

  always_comb begin
    // One extra bit on the far edge so a sprite hanging off the right/bottom does not wrap to 0
    x_end    = {1'b0, attr.x} + XW'(attr.w);
    y_end    = {1'b0, attr.y} + XW'(attr.h);
    s0_hit_d = attr.en && (px >= attr.x) && ({1'b0, px} < x_end)
                       && (py >= attr.y) && ({1'b0, py} < y_end);
    dx_d     = SZ_W'(px - attr.x);
    dy_d     = SZ_W'(py - attr.y);
    w_d      = attr.w;
    base_d   = attr.base;
`ifdef SPR_FLIP_EN
    flip_d   = attr.flip;
    dx_eff   = flip_q ? (w_q - SZ_W'(1) - dx_q) : dx_q;
`else
    dx_eff   = dx_q;
`endif
    s1_hit_d = s0_hit_q;
    addr_d   = TEX_AW'(SUM_W'(base_q) + SUM_W'(dy_q) * SUM_W'(w_q) + SUM_W'(dx_eff));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_hit_q <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      w_q      <= '0;
      base_q   <= '0;
`ifdef SPR_FLIP_EN
      flip_q   <= 1'b0;
`endif
      s1_hit_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      s0_hit_q <= s0_hit_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      w_q      <= w_d;
      base_q   <= base_d;
`ifdef SPR_FLIP_EN
      flip_q   <= flip_d;
`endif
      s1_hit_q <= s1_hit_d;
      addr_q   <= addr_d;
    end
  end

  assign hit_o  = s1_hit_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/sprite_compositor.sv
// N-slot sprite compositor over a background stream; 3-clk fixed latency, 1 pixel/clk, no backpressure.
// Build option: SPR_FLIP_EN enables the per-slot horizontal mirror.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int               NUM_SPR   = 4,
  parameter logic [PIX_W-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  sprite_compositor_if.slave  bus
);
  attr_t             shadow_d [NUM_SPR];
  attr_t             shadow_q [NUM_SPR];
  attr_t             active_d [NUM_SPR];
  attr_t             active_q [NUM_SPR];
  attr_t             new_attr;
  logic              vld_s0_d, vld_s0_q, vld_s1_d, vld_s1_q;
  logic [PIX_W-1:0]  bg_s0_d, bg_s0_q, bg_s1_d, bg_s1_q;
  logic              pix_valid_o_d, pix_valid_o_q;
  logic [PIX_W-1:0]  pixel_out_d, pixel_out_q;
  logic              hit   [NUM_SPR];
  logic [TEX_AW-1:0] addr  [NUM_SPR];
  logic              a_vld, b_vld;
  logic [TEX_AW-1:0] a_addr, b_addr;
  logic [PIX_W-1:0]  tex_a, tex_b;
  logic [PIX_W-1:0]  tex_mem [2**TEX_AW];
`ifndef SPR_FLIP_EN
  logic              unused_flip;
  assign unused_flip = bus.attr_flip;
`endif

  always_comb begin
    new_attr.en   = bus.attr_en;
`ifdef SPR_FLIP_EN
    new_attr.flip = bus.attr_flip;
`endif
    new_attr.x    = bus.attr_x;
    new_attr.y    = bus.attr_y;
    new_attr.w    = bus.attr_w;
    new_attr.h    = bus.attr_h;
    new_attr.base = bus.attr_base;
  end

  // Active takes the pre-write shadow, so a write coinciding with frame_en commits one frame later
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (bus.frame_en)
      active_d = shadow_q;
    if (bus.attr_wr_en && (int'(bus.attr_wr_idx) < NUM_SPR))
      shadow_d[bus.attr_wr_idx] = new_attr;
  end

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_slot
    sprite_hit_unit u_hit (
      .clk    (clk),
      .rst_n  (rst_n),
      .px     (bus.pixel_x),
      .py     (bus.pixel_y),
      .attr   (active_q[i]),
      .hit_o  (hit[i]),
      .addr_o (addr[i])
    );
  end

  always_comb begin
    a_vld  = 1'b0;
    b_vld  = 1'b0;
    a_addr = '0;
    b_addr = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (hit[i] && !a_vld) begin
        a_vld  = 1'b1;
        a_addr = addr[i];
      end else if (hit[i] && !b_vld) begin
        b_vld  = 1'b1;
        b_addr = addr[i];
      end
    end
  end

  // Asynchronous read ahead of the output register: a same-cycle write lands after the read
  always_ff @(posedge clk) begin
    if (bus.tex_wr_en)
      tex_mem[bus.tex_wr_addr] <= bus.tex_wr_data;
  end
  assign tex_a = tex_mem[a_addr];
  assign tex_b = tex_mem[b_addr];

  always_comb begin
    vld_s0_d      = bus.pix_valid;
    bg_s0_d       = bus.bg_data;
    vld_s1_d      = vld_s0_q;
    bg_s1_d       = bg_s0_q;
    pix_valid_o_d = vld_s1_q;
    if (a_vld && (tex_a != KEY_COLOR))
      pixel_out_d = tex_a;
    else if (b_vld && (tex_b != KEY_COLOR))
      pixel_out_d = tex_b;
    else
      pixel_out_d = bg_s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      vld_s0_q      <= 1'b0;
      bg_s0_q       <= '0;
      vld_s1_q      <= 1'b0;
      bg_s1_q       <= '0;
      pix_valid_o_q <= 1'b0;
      pixel_out_q   <= '0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      vld_s0_q      <= vld_s0_d;
      bg_s0_q       <= bg_s0_d;
      vld_s1_q      <= vld_s1_d;
      bg_s1_q       <= bg_s1_d;
      pix_valid_o_q <= pix_valid_o_d;
      pixel_out_q   <= pixel_out_d;
    end
  end

  assign bus.pix_valid_o = pix_valid_o_q;
  assign bus.pixel_out   = pixel_out_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised plus directed bench for sprite_compositor: a queue-based scoreboard fed by a
// slot-by-slot reference model, drained by a negedge monitor.
module tb_sprite_compositor;

  localparam int N     = 4;
  localparam int DEPTH = 16384;
  localparam logic [15:0] KEY = 16'hFFFF;

  typedef struct {
    int x; int y; int w; int h; int base; bit en; bit flip;
  } mattr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_compositor_if #(.NUM_SPR(N)) bus ();
  sprite_compositor #(.NUM_SPR(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  mattr_t      m_shadow [N];
  mattr_t      m_active [N];
  logic [15:0] m_tex [DEPTH];
  logic [15:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;

  // Reference: scan slots in priority order, consider at most the first two hits
  function automatic logic [15:0] model_pix(input int px, input int py, input logic [15:0] bg);
    int nhit = 0;
    for (int s = 0; s < N; s++) begin
      if (m_active[s].en && px >= m_active[s].x && px < m_active[s].x + m_active[s].w &&
          py >= m_active[s].y && py < m_active[s].y + m_active[s].h) begin
        int dx = px - m_active[s].x;
        int a;
`ifdef SPR_FLIP_EN
        if (m_active[s].flip) dx = m_active[s].w - 1 - dx;
`endif
        a = (m_active[s].base + (py - m_active[s].y) * m_active[s].w + dx) % DEPTH;
        if (m_tex[a] != KEY) return m_tex[a];
        nhit++;
        if (nhit == 2) return bg;
      end
    end
    return bg;
  endfunction

  function automatic mattr_t mk(int x, int y, int w, int h, int base, bit en, bit flip);
    mattr_t a;
    a.x = x; a.y = y; a.w = w; a.h = h; a.base = base; a.en = en; a.flip = flip;
    return a;
  endfunction

  function automatic mattr_t rnd_attr();
    return mk($urandom_range(0, 300), $urandom_range(0, 300), $urandom_range(0, 120),
              $urandom_range(0, 120), $urandom_range(0, DEPTH - 1),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; model sees the pixel against the table as it stood before this edge
  task automatic cycle(input bit v, input int x, input int y, input logic [15:0] bg,
                       input bit fr, input bit aw, input int idx, input mattr_t a);
    if (v) exp_q.push_back(model_pix(x, y, bg));
    if (fr) m_active = m_shadow;
    if (aw) m_shadow[idx] = a;
    bus.pix_valid   = v;
    bus.pixel_x     = 11'(x);
    bus.pixel_y     = 11'(y);
    bus.bg_data     = bg;
    bus.frame_en    = fr;
    bus.attr_wr_en  = aw;
    bus.attr_wr_idx = 2'(idx);
    bus.attr_x      = 11'(a.x);
    bus.attr_y      = 11'(a.y);
    bus.attr_w      = 9'(a.w);
    bus.attr_h      = 9'(a.h);
    bus.attr_base   = 14'(a.base);
    bus.attr_en     = a.en;
    bus.attr_flip   = a.flip;
    tick();
    bus.pix_valid  = 1'b0;
    bus.frame_en   = 1'b0;
    bus.attr_wr_en = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    cycle(1'b1, x, y, 16'($urandom), 1'b0, 1'b0, 0, mk(0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic wr_attr(input int idx, input mattr_t a, input bit fr);
    cycle(1'b0, 0, 0, 16'h0, fr, 1'b1, idx, a);
  endtask

  task automatic frame();
    cycle(1'b0, 0, 0, 16'h0, 1'b1, 1'b0, 0, mk(0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic tex_wr(input int a, input logic [15:0] d);
    m_tex[a]        = d;
    bus.tex_wr_en   = 1'b1;
    bus.tex_wr_addr = 14'(a);
    bus.tex_wr_data = d;
    tick();
    bus.tex_wr_en   = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.pix_valid_o) begin
      rx_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid: got pixel %0h with nothing expected", bus.pixel_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus.pixel_out !== e) begin
          errors++;
          $display("FAIL pixel_out @%0t: got %0h expected %0h", $time, bus.pixel_out, e);
        end
      end
    end
  end

  initial begin
    int rx0;
    for (int s = 0; s < N; s++) begin
      m_shadow[s] = mk(0, 0, 0, 0, 0, 0, 0);
      m_active[s] = m_shadow[s];
    end
    bus.pix_valid = 0; bus.pixel_x = 0; bus.pixel_y = 0; bus.bg_data = 0; bus.frame_en = 0;
    bus.tex_wr_en = 0; bus.tex_wr_addr = 0; bus.tex_wr_data = 0;
    bus.attr_wr_en = 0; bus.attr_wr_idx = 0; bus.attr_x = 0; bus.attr_y = 0; bus.attr_w = 0;
    bus.attr_h = 0; bus.attr_base = 0; bus.attr_en = 0; bus.attr_flip = 0;

    repeat (3) tick();
    check("reset_valid", 32'(bus.pix_valid_o), 32'd0);
    check("reset_pixel", 32'(bus.pixel_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // Texture k = k, plus nothing enabled yet: everything is background
    for (int k = 0; k < DEPTH; k++) tex_wr(k, 16'(k));
    for (int i = 0; i < 8; i++) pix($urandom_range(0, 639), $urandom_range(0, 479));
    frame();
    pix(117, 52);

    // Single sprite: (117,52) reads texel 117, (150,52) is just past the right edge
    wr_attr(0, mk(100, 50, 50, 35, 0, 1, 0), 1'b0);
    frame();
    pix(117, 52);
    pix(150, 52);
    pix(149, 84);
    pix(100, 85);

    // Shadow: write without frame, write coinciding with frame, then a plain frame
    wr_attr(0, mk(200, 50, 50, 35, 0, 1, 0), 1'b0);
    pix(117, 52); pix(217, 52);
    wr_attr(0, mk(400, 50, 50, 35, 0, 1, 0), 1'b1);
    pix(117, 52); pix(217, 52); pix(417, 52);
    frame();
    pix(117, 52); pix(217, 52); pix(417, 52);

    // Transparency through two stacked slots
    wr_attr(0, mk(300, 300, 4, 4, 1000, 1, 0), 1'b0);
    wr_attr(1, mk(300, 300, 4, 4, 2000, 1, 0), 1'b0);
    frame();
    drain();
    tex_wr(1000, 16'hFFFF); tex_wr(2000, 16'h07E0);
    pix(300, 300);
    drain();
    tex_wr(2000, 16'hFFFF);
    pix(300, 300);
    drain();
    tex_wr(1000, 16'h001F);
    pix(300, 300);

    // Mirror: dx=0 reads base+49 with SPR_FLIP_EN, base+0 without
    wr_attr(2, mk(600, 100, 50, 2, 5000, 1, 1), 1'b0);
    frame();
    pix(600, 100); pix(649, 101); pix(610, 100);

    // Right edge beyond the coordinate range must not wrap onto column 5
    wr_attr(3, mk(2040, 0, 20, 100, 7000, 1, 0), 1'b0);
    frame();
    pix(5, 10); pix(2045, 10); pix(2047, 99);

    // Sprinkle colour keys, then 1024 back-to-back pixels with live table traffic
    drain();
    for (int i = 0; i < 2000; i++) tex_wr($urandom_range(0, DEPTH - 1), KEY);
    for (int s = 0; s < N; s++) wr_attr(s, rnd_attr(), 1'b0);
    frame();
    drain();
    rx0 = rx_cnt;
    for (int i = 0; i < 1024; i++)
      cycle(1'b1, $urandom_range(0, 420), $urandom_range(0, 420), 16'($urandom),
            $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, N - 1),
            rnd_attr());
    drain();
    check("burst_count", 32'(rx_cnt - rx0), 32'd1024);

    // Mid-stream reset: in-flight pixels dropped, tables cleared, texture kept
    for (int i = 0; i < 2; i++) pix(300, 300);
    rst_n = 1'b0;
    exp_q.delete();
    for (int s = 0; s < N; s++) begin
      m_shadow[s] = mk(0, 0, 0, 0, 0, 0, 0);
      m_active[s] = m_shadow[s];
    end
    #1;
    check("midreset_valid", 32'(bus.pix_valid_o), 32'd0);
    check("midreset_pixel", 32'(bus.pixel_out), 32'd0);
    tick();
    check("midreset_hold_valid", 32'(bus.pix_valid_o), 32'd0);
    rst_n = 1'b1;
    tick();
    pix(117, 52); pix(300, 300);
    frame();
    pix(300, 300);
    wr_attr(0, mk(300, 300, 4, 4, 1000, 1, 0), 1'b0);
    frame();
    pix(300, 300);
    pix(301, 300);

    begin
      int budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        tick();
        budget--;
      end
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
